// File: rtl/ext_mem_responder.sv
// Fixed-latency byte-array responder for a Bambu accelerator master memory port.
// Each channel has its own IDLE/BUSY/RESP sequencer; a byte-wide port preloads and reads back the array.
module ext_mem_responder #(
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 64,
  parameter int SIZE_W      = 7,
  parameter int MEMSIZE     = 32,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          Mout_oe_ram,
  input  logic [CHANNELS-1:0]          Mout_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [CHANNELS*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [CHANNELS*SIZE_W-1:0]   Mout_data_ram_size,
  output logic [CHANNELS*DATA_W-1:0]   M_Rdata_ram,
  output logic [CHANNELS-1:0]          M_DataRdy,
  input  logic                         ld_en,
  input  logic                         ld_we,
  input  logic [ADDR_W-1:0]            ld_addr,
  input  logic [7:0]                   ld_wdata,
  output logic [7:0]                   ld_rdata,
  output logic [2:0]                   err
);

  localparam int NBYTES    = DATA_W / 8;
  localparam int MEM_AW    = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);
  localparam int NB_W      = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Unsupported or oversized size codes fall back to a full-width access.
  function automatic logic [NB_W-1:0] size_to_bytes(input logic [SIZE_W-1:0] size);
    logic [NB_W-1:0] n;
    n = NB_W'(NBYTES);
    case (size)
      SIZE_W'(8), SIZE_W'(16), SIZE_W'(32), SIZE_W'(64): begin
        if (int'(size) <= DATA_W) n = NB_W'(size >> 3);
        else n = NB_W'(NBYTES);
      end
      default: n = NB_W'(NBYTES);
    endcase
    return n;
  endfunction

  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr, input logic [NB_W-1:0] n);
    return (int'(addr) + int'(n)) > MEMSIZE;
  endfunction

  state_t                    state_q [CHANNELS];
  state_t                    state_d [CHANNELS];
  logic [CNT_W-1:0]          cnt_q   [CHANNELS];
  logic [CNT_W-1:0]          cnt_d   [CHANNELS];
  logic [ADDR_W-1:0]         addr_q  [CHANNELS];
  logic [ADDR_W-1:0]         addr_d  [CHANNELS];
  logic [NB_W-1:0]           nb_q    [CHANNELS];
  logic [NB_W-1:0]           nb_d    [CHANNELS];
  logic [CHANNELS-1:0]       wr_q, wr_d;
  logic [CHANNELS-1:0]       rdy_q, rdy_d;
  logic [CHANNELS*DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]                mem_q   [MEMSIZE];
  logic [7:0]                mem_d   [MEMSIZE];
  logic [7:0]                ld_rdata_q, ld_rdata_d;
  logic [2:0]                err_q, err_d;

  logic [CHANNELS-1:0]       accept_s, cur_wr_s, cur_oor_s;
  logic [ADDR_W-1:0]         cur_addr_s [CHANNELS];
  logic [NB_W-1:0]           cur_nb_s   [CHANNELS];
  logic                      busy_s, ld_ok_s, ld_in_range_s;

  // Current access per channel: live inputs while idle, latched fields otherwise.
  always_comb begin
    busy_s = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (state_q[i] == ST_IDLE) begin
        cur_addr_s[i] = Mout_addr_ram[i*ADDR_W +: ADDR_W];
        cur_nb_s[i]   = size_to_bytes(Mout_data_ram_size[i*SIZE_W +: SIZE_W]);
        cur_wr_s[i]   = Mout_we_ram[i];
        accept_s[i]   = Mout_oe_ram[i] | Mout_we_ram[i];
      end else begin
        cur_addr_s[i] = addr_q[i];
        cur_nb_s[i]   = nb_q[i];
        cur_wr_s[i]   = wr_q[i];
        accept_s[i]   = 1'b0;
        busy_s        = 1'b1;
      end
      cur_oor_s[i] = out_of_range(cur_addr_s[i], cur_nb_s[i]);
    end
    ld_ok_s       = ld_en & ~busy_s & ~(|accept_s);
    ld_in_range_s = int'(ld_addr) < MEMSIZE;
  end

  // Per-channel sequencer, completion pulse and read-data capture.
  always_comb begin
    rdy_d   = {CHANNELS{1'b0}};
    rdata_d = rdata_q;
    wr_d    = wr_q;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      addr_d[i]  = addr_q[i];
      nb_d[i]    = nb_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (accept_s[i]) begin
            addr_d[i] = cur_addr_s[i];
            nb_d[i]   = cur_nb_s[i];
            wr_d[i]   = cur_wr_s[i];
            if ((cur_wr_s[i] && WRITE_DELAY == 1) || (!cur_wr_s[i] && READ_DELAY == 1)) begin
              state_d[i] = ST_RESP;
              cnt_d[i]   = {CNT_W{1'b0}};
            end else begin
              state_d[i] = ST_BUSY;
              cnt_d[i]   = cur_wr_s[i] ? CNT_W'(WRITE_DELAY - 1) : CNT_W'(READ_DELAY - 1);
            end
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_q[i] <= CNT_W'(1)) begin
            state_d[i] = ST_RESP;
            cnt_d[i]   = {CNT_W{1'b0}};
          end else begin
            cnt_d[i]   = cnt_q[i] - CNT_W'(1);
          end
        end
        ST_RESP: state_d[i] = ST_IDLE;
        default: state_d[i] = ST_IDLE;
      endcase
      rdy_d[i] = (state_d[i] == ST_RESP);
      if (rdy_d[i] && !cur_wr_s[i]) begin
        for (int k = 0; k < NBYTES; k++) begin
          if (k < int'(cur_nb_s[i]) && !cur_oor_s[i]) begin
            rdata_d[i*DATA_W + k*8 +: 8] = mem_q[MEM_AW'(int'(cur_addr_s[i]) + k)];
          end else begin
            rdata_d[i*DATA_W + k*8 +: 8] = 8'h00;
          end
        end
      end else begin
        rdata_d[i*DATA_W +: DATA_W] = rdata_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // Array updates, preload readback and sticky error flags.
  always_comb begin
    mem_d      = mem_q;
    ld_rdata_d = ld_rdata_q;
    err_d      = err_q;
    // Ascending channel order lets the highest index win a same-byte collision.
    for (int i = 0; i < CHANNELS; i++) begin
      if (accept_s[i]) begin
        if (cur_oor_s[i]) err_d[0] = 1'b1;
        else err_d[0] = err_d[0];
        if (Mout_oe_ram[i] && Mout_we_ram[i]) err_d[1] = 1'b1;
        else err_d[1] = err_d[1];
        if (cur_wr_s[i] && !cur_oor_s[i]) begin
          for (int k = 0; k < NBYTES; k++) begin
            if (k < int'(cur_nb_s[i])) begin
              mem_d[MEM_AW'(int'(cur_addr_s[i]) + k)] = Mout_Wdata_ram[i*DATA_W + k*8 +: 8];
            end else begin
              mem_d[MEM_AW'(int'(cur_addr_s[i]))] = mem_d[MEM_AW'(int'(cur_addr_s[i]))];
            end
          end
        end else begin
          err_d = err_d;
        end
      end else begin
        err_d = err_d;
      end
    end
    if (ld_en && !ld_ok_s) begin
      err_d[2] = 1'b1;
    end else if (ld_ok_s) begin
      if (!ld_in_range_s) begin
        err_d[0] = 1'b1;
        if (!ld_we) ld_rdata_d = 8'h00;
        else ld_rdata_d = ld_rdata_q;
      end else if (ld_we) begin
        mem_d[MEM_AW'(ld_addr)] = ld_wdata;
      end else begin
        ld_rdata_d = mem_q[MEM_AW'(ld_addr)];
      end
    end else begin
      ld_rdata_d = ld_rdata_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= {CNT_W{1'b0}};
        addr_q[i]  <= {ADDR_W{1'b0}};
        nb_q[i]    <= {NB_W{1'b0}};
      end
      wr_q       <= {CHANNELS{1'b0}};
      rdy_q      <= {CHANNELS{1'b0}};
      rdata_q    <= {(CHANNELS*DATA_W){1'b0}};
      ld_rdata_q <= 8'h00;
      err_q      <= 3'b000;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        addr_q[i]  <= addr_d[i];
        nb_q[i]    <= nb_d[i];
      end
      wr_q       <= wr_d;
      rdy_q      <= rdy_d;
      rdata_q    <= rdata_d;
      ld_rdata_q <= ld_rdata_d;
      err_q      <= err_d;
    end
  end

  // Array storage survives reset so preloaded and written data stay readable.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign M_DataRdy   = rdy_q;
  assign M_Rdata_ram = rdata_q;
  assign ld_rdata    = ld_rdata_q;
  assign err         = err_q;

endmodule

// File: doc/ext_mem_responder.md
# ext_mem_responder

Synthesizable external-memory responder for the master memory port of a Bambu-generated accelerator (`main`). It answers the accelerator's outgoing read and write requests from an internal byte array. Each request completes after a fixed per-operation latency, which reproduces the read/write delays used in simulation so the same setup can run on FPGA. A byte-wide preload port lets a host or bench initialise the array before `start_port` and read results back afterwards.

## Interface
- CHANNELS, 2, independent request channels (one per accelerator memory port)
- ADDR_W, 7, byte-address width per channel
- DATA_W, 64, data width per channel (multiple of 8)
- SIZE_W, 7, access-size field width per channel (size in bits)
- MEMSIZE, 32, bytes in the array (≤ 2^ADDR_W)
- READ_DELAY, 2, read latency in cycles (≥1)
- WRITE_DELAY, 1, write latency in cycles (≥1)

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- Mout_oe_ram  in  CHANNELS  read request per channel
- Mout_we_ram  in  CHANNELS  write request per channel
- Mout_addr_ram  in  CHANNELS*ADDR_W  byte address, channel i at slice i
- Mout_Wdata_ram  in  CHANNELS*DATA_W  write data, little-endian
- Mout_data_ram_size  in  CHANNELS*SIZE_W  access size in bits: 8/16/32/64
- M_Rdata_ram  out  CHANNELS*DATA_W  read data
- M_DataRdy  out  CHANNELS  one-cycle completion pulse
- ld_en  in  1  preload/readback strobe
- ld_we  in  1  1 = write ld_wdata, 0 = read
- ld_addr  in  ADDR_W  preload byte address
- ld_wdata  in  8  preload byte
- ld_rdata  out  8  readback byte, registered
- err  out  3  sticky flags: [0] out-of-range, [1] oe&we together, [2] load while busy

## Operation
- Each channel runs its own FSM.
  - IDLE: accepts a request when `oe` or `we` is high. Latches addr, size, wdata and op. Loads a counter with the op delay minus 1. Moves to BUSY (or to RESP if the delay is 1).
  - BUSY: decrements the counter. At 0 it moves to RESP.
  - RESP: drives `M_DataRdy[i]=1` for one cycle, then returns to IDLE. A request present during RESP is not accepted; it must still be present in IDLE.
- Byte count = size>>3. Any other size value is treated as DATA_W.
- Write: in the acceptance cycle, bytes [addr, addr+n) are taken from wdata bits [8n-1:0] and committed at the closing edge.
- Read: bytes are sampled at the edge entering RESP and registered into `M_Rdata_ram` slice i. Bits above 8n are zero. The slice holds its value until the next read completes on that channel.
- Out of range (addr+n > MEMSIZE): a write is dropped; a read returns 0. Sets err[0]. The normal DataRdy timing still applies.
- oe and we both high: treated as a write. Sets err[1].
- Same-cycle writes to one byte from several channels: the highest channel index wins.
- A read sampling in the same edge as a write commit sees the old byte.
- Preload:
  - Accepted only when all channels are IDLE and none is accepting a request that cycle.
  - Otherwise ignored and err[2] is set.
  - Write commits at the edge.
  - Read gives `ld_rdata` one cycle later.
  - An out-of-range address writes nothing, reads 0, and sets err[0].
- The array has no reset. Its contents are preserved across reset.

## Timing
- Reset (reset=0 at an edge): all FSMs go to IDLE, counters clear, `M_DataRdy=0`, `M_Rdata_ram=0`, `ld_rdata=0`, `err=0`.
  - Reset mid-transaction aborts the transaction with no DataRdy.
  - A write already committed stays committed.
- Request high in cycle c (channel in IDLE): DataRdy is high in cycle c+READ_DELAY (read) or c+WRITE_DELAY (write). Rdata is valid in the same cycle as DataRdy.
- A request held continuously is re-accepted at cycle c+delay+1. Back-to-back throughput is one access per delay+1 cycles per channel.
- Channels are fully independent. Simultaneous DataRdy pulses are allowed.

## Test plan
- Reset with all inputs 0:
  - Outputs are 0 and err=0 throughout.
  - Array contents written before reset are readable afterwards.
- Preload and write:
  - Preload bytes 0..7 = 0x11..0x88, then read ch0 addr 0 size 32 with oe high at cycle 10.
  - DataRdy[0] is high only at cycle 12; Rdata slice 0 = 0x0000_0000_4433_2211.
- Write ch1 addr 4 size 16 wdata 0xBEEF at cycle 20:
  - DataRdy[1] is high at 21.
  - A subsequent preload readback of bytes 4,5 gives 0xEF, 0xBE.
- Both channels write size 8 to addr 3 (ch0 0xAA, ch1 0x55) in the same cycle:
  - Byte 3 = 0x55.
  - Both DataRdy pulses occur one cycle later.
- ch0 read addr 30 size 32:
  - DataRdy occurs at +2, Rdata=0, err[0]=1.
  - A later `oe&we` request sets err[1].
- ld_en write while ch0 is BUSY:
  - The byte is unchanged and err[2]=1.
- Reset asserted in BUSY:
  - No DataRdy is seen.
  - The next request completes with the normal latency.
